// File: rtl/systarr_ctrl_if.sv
// rtl/systarr_ctrl_if.sv - job request and array-control bundle for the DTW systolic sequencer
// i_stall is present only when SYSTARR_CTRL_STALL_EN is defined.
interface systarr_ctrl_if #(
    parameter int NPE  = 6,
    parameter int IDXW = 5
);
    logic             i_start;
    logic [5:0]       i_tlen;
    logic [5:0]       i_rlen;
`ifdef SYSTARR_CTRL_STALL_EN
    logic             i_stall;
`endif
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic             o_ena;
    logic [IDXW-1:0]  o_tindex;
    logic [IDXW-1:0]  o_rindex;
    logic [IDXW-1:0]  o_taddr;
    logic [IDXW-1:0]  o_raddr;
    logic [2*NPE-1:0] o_tsrc;
    logic [2*NPE-1:0] o_rsrc;
    logic [NPE-1:0]   o_colvalid;
    logic [2:0]       o_tile;

    modport master (
`ifdef SYSTARR_CTRL_STALL_EN
        output i_stall,
`endif
        output i_start, i_tlen, i_rlen,
        input  o_busy, o_done, o_err, o_ena, o_tindex, o_rindex, o_taddr, o_raddr,
        input  o_tsrc, o_rsrc, o_colvalid, o_tile
    );

    modport slave (
`ifdef SYSTARR_CTRL_STALL_EN
        input  i_stall,
`endif
        input  i_start, i_tlen, i_rlen,
        output o_busy, o_done, o_err, o_ena, o_tindex, o_rindex, o_taddr, o_raddr,
        output o_tsrc, o_rsrc, o_colvalid, o_tile
    );
endinterface

// File: rtl/systarr_ctrl.sv
// rtl/systarr_ctrl.sv - tile/wavefront sequencer for the 6-PE DTW systolic array
// Optional pause input enabled by defining SYSTARR_CTRL_STALL_EN.
module systarr_ctrl #(
    parameter int NPE    = 6,
    parameter int IDXW   = 5,
    parameter int MAXLEN = 32
) (
    input  logic          clk,
    input  logic          nrst,
    systarr_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RLOAD = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [5:0]       tlen_q, tlen_d;
    logic [5:0]       rlen_q, rlen_d;
    logic [2:0]       tile_q, tile_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ena_q, ena_d;
    logic [IDXW-1:0]  tindex_q, tindex_d;
    logic [IDXW-1:0]  rindex_q, rindex_d;
    logic [2*NPE-1:0] tsrc_q, tsrc_d;
    logic [2*NPE-1:0] rsrc_q, rsrc_d;
    logic [NPE-1:0]   colvalid_q, colvalid_d;

    logic             stall;
    logic             frozen;
    logic             start_ok;
    logic             last_step;
    logic             last_tile;
    logic [6:0]       col;

`ifdef SYSTARR_CTRL_STALL_EN
    assign stall = bus.i_stall;
`else
    assign stall = 1'b0;
`endif

    assign frozen    = stall && (state_q == S_RLOAD || state_q == S_RUN);
    assign start_ok  = (bus.i_tlen != 6'd0) && (bus.i_tlen <= 6'(MAXLEN)) &&
                       (bus.i_rlen != 6'd0) && (bus.i_rlen <= 6'(MAXLEN));
    // A wavefront needs tlen+NPE-1 steps to drain through all PEs.
    assign last_step = ({1'b0, cnt_q} == 7'(tlen_q) + 7'(NPE - 2));
    assign last_tile = ((7'(tile_q) + 7'd1) * 7'(NPE) >= 7'(rlen_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tile_d  = tile_q;
        tlen_d  = tlen_q;
        rlen_d  = rlen_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    if (start_ok) begin
                        tlen_d  = bus.i_tlen;
                        rlen_d  = bus.i_rlen;
                        tile_d  = 3'd0;
                        cnt_d   = 6'd0;
                        state_d = S_RLOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RLOAD: begin
                if (!frozen) begin
                    if (cnt_q == 6'(NPE - 1)) begin
                        cnt_d   = 6'd0;
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_RUN: begin
                if (!frozen) begin
                    if (last_step) begin
                        cnt_d = 6'd0;
                        if (last_tile) begin
                            state_d = S_DONE;
                        end else begin
                            tile_d  = tile_q + 3'd1;
                            state_d = S_RLOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_DONE: begin
                tile_d  = 3'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    assign col = 7'(tile_d) * 7'(NPE) + 7'(cnt_d);

    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        ena_d      = 1'b0;
        tsrc_d     = '0;
        rsrc_d     = '0;
        tindex_d   = '0;
        rindex_d   = '0;
        colvalid_d = (state_q == S_IDLE) ? '0 : colvalid_q;
        if (frozen) begin
            tindex_d = tindex_q;
            rindex_d = rindex_q;
        end else if (state_d == S_RLOAD) begin
            ena_d = 1'b1;
            for (int k = 0; k < NPE; k++) begin
                if (cnt_d == 6'(k)) begin
                    if (col < {1'b0, rlen_d}) begin
                        rsrc_d[2*(NPE-1-k) +: 2] = 2'b10;
                        colvalid_d[NPE-1-k]      = 1'b1;
                        rindex_d                 = col[IDXW-1:0];
                    end else begin
                        rsrc_d[2*(NPE-1-k) +: 2] = 2'b11;
                        colvalid_d[NPE-1-k]      = 1'b0;
                    end
                end
            end
        end else if (state_d == S_RUN) begin
            ena_d  = 1'b1;
            tsrc_d = {(cnt_d < tlen_d) ? 2'b10 : 2'b11, {(NPE - 1){2'b01}}};
            if (cnt_d < tlen_d) begin
                tindex_d = cnt_d[IDXW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tlen_q     <= '0;
            rlen_q     <= '0;
            tile_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ena_q      <= 1'b0;
            tindex_q   <= '0;
            rindex_q   <= '0;
            tsrc_q     <= '0;
            rsrc_q     <= '0;
            colvalid_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tlen_q     <= tlen_d;
            rlen_q     <= rlen_d;
            tile_q     <= tile_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ena_q      <= ena_d;
            tindex_q   <= tindex_d;
            rindex_q   <= rindex_d;
            tsrc_q     <= tsrc_d;
            rsrc_q     <= rsrc_d;
            colvalid_q <= colvalid_d;
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_err      = err_q;
    assign bus.o_ena      = ena_q;
    assign bus.o_tindex   = tindex_q;
    assign bus.o_rindex   = rindex_q;
    assign bus.o_taddr    = tindex_q;
    assign bus.o_raddr    = rindex_q;
    assign bus.o_tsrc     = tsrc_q;
    assign bus.o_rsrc     = rsrc_q;
    assign bus.o_colvalid = colvalid_q;
    assign bus.o_tile     = tile_q;
endmodule

// File: tb/tb_systarr_ctrl.sv
// tb/tb_systarr_ctrl.sv - randomized schedule-model bench for systarr_ctrl
// Stall scenarios are exercised only when SYSTARR_CTRL_STALL_EN is defined.
`define CHK(nm, a, e) chk(nm, 32'(a), 32'(e))

module tb_systarr_ctrl;
    localparam int NPE = 6;

    logic clk      = 1'b0;
    logic nrst     = 1'b0;
    logic stall_in = 1'b0;
    bit   chk_on   = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    systarr_ctrl_if #(.NPE(NPE), .IDXW(5)) bus ();
`ifdef SYSTARR_CTRL_STALL_EN
    assign bus.i_stall = stall_in;
`endif

    systarr_ctrl dut (.clk(clk), .nrst(nrst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic bad(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_fail++;
        $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    endtask

    typedef struct packed {
        logic [1:0]  ph;
        logic        busy, done, err, ena;
        logic [4:0]  ti, ri;
        logic [11:0] ts, rs;
        logic [5:0]  cv;
        logic [2:0]  tile;
    } exp_t;

    exp_t cur;
    exp_t sched[$];

    function automatic void build(int tl, int rl);
        exp_t e;
        int nt, col;
        logic [5:0] cv;
        nt = (rl + NPE - 1) / NPE;
        for (int t = 0; t < nt; t++) begin
            cv = '0;
            for (int k = 0; k < NPE; k++) if (t * NPE + k < rl) cv[NPE-1-k] = 1'b1;
            for (int k = 0; k < NPE; k++) begin
                col = t * NPE + k;
                e = '0; e.ph = 2'd1; e.busy = 1'b1; e.ena = 1'b1; e.tile = 3'(t);
                e.rs = 12'(((col < rl) ? 2 : 3) << (2 * (NPE - 1 - k)));
                e.ri = (col < rl) ? 5'(col) : 5'd0;
                sched.push_back(e);
            end
            for (int s = 0; s < tl + NPE - 1; s++) begin
                e = '0; e.ph = 2'd2; e.busy = 1'b1; e.ena = 1'b1; e.tile = 3'(t); e.cv = cv;
                e.ts = 12'(((s < tl) ? 2 : 3) * 1024 + 'h155);
                e.ti = (s < tl) ? 5'(s) : 5'd0;
                sched.push_back(e);
            end
        end
        e = '0; e.ph = 2'd3; e.busy = 1'b1; e.done = 1'b1;
        sched.push_back(e);
    endfunction

    always @(posedge clk or negedge nrst) begin
        exp_t nx;
        if (!nrst) begin
            sched.delete();
            cur <= '0;
        end else begin
            nx = cur;
            if (cur.ph == 2'd0) begin
                nx = '0;
                if (bus.i_start) begin
                    if (bus.i_tlen >= 1 && bus.i_tlen <= 32 && bus.i_rlen >= 1 && bus.i_rlen <= 32) begin
                        build(int'(bus.i_tlen), int'(bus.i_rlen));
                        nx = sched.pop_front();
                    end else begin
                        nx.err = 1'b1;
                    end
                end
            end else if (stall_in && (cur.ph == 2'd1 || cur.ph == 2'd2)) begin
                nx.ena = 1'b0; nx.ts = '0; nx.rs = '0;
            end else begin
                nx = (sched.size() > 0) ? sched.pop_front() : '0;
            end
            cur <= nx;
        end
    end

    always @(posedge clk) begin
        #1;
        if (nrst && chk_on) begin
            n_tests += 10;
            if (bus.o_busy !== cur.busy) bad("busy", 32'(bus.o_busy), 32'(cur.busy));
            if (bus.o_done !== cur.done) bad("done", 32'(bus.o_done), 32'(cur.done));
            if (bus.o_err !== cur.err) bad("err", 32'(bus.o_err), 32'(cur.err));
            if (bus.o_ena !== cur.ena) bad("ena", 32'(bus.o_ena), 32'(cur.ena));
            if (bus.o_tindex !== cur.ti) bad("tindex", 32'(bus.o_tindex), 32'(cur.ti));
            if (bus.o_taddr !== cur.ti) bad("taddr", 32'(bus.o_taddr), 32'(cur.ti));
            if (bus.o_rindex !== cur.ri) bad("rindex", 32'(bus.o_rindex), 32'(cur.ri));
            if (bus.o_raddr !== cur.ri) bad("raddr", 32'(bus.o_raddr), 32'(cur.ri));
            if (bus.o_tsrc !== cur.ts) bad("tsrc", 32'(bus.o_tsrc), 32'(cur.ts));
            if (bus.o_rsrc !== cur.rs) bad("rsrc", 32'(bus.o_rsrc), 32'(cur.rs));
            if (cur.ph == 2'd1 || cur.ph == 2'd2) begin
                n_tests++;
                if (bus.o_tile !== cur.tile) bad("tile", 32'(bus.o_tile), 32'(cur.tile));
            end
            if (cur.ph == 2'd2) begin
                n_tests++;
                if (bus.o_colvalid !== cur.cv) bad("colvalid", 32'(bus.o_colvalid), 32'(cur.cv));
            end
        end
    end

    function automatic logic [5:0] pick_len();
        if ($urandom_range(0, 9) == 0)
            return ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(33, 63));
        return 6'($urandom_range(1, 32));
    endfunction

    task automatic run_job(input int tl, input int rl, input int stall_at, input int pulse_at,
                           input int cap_at, output int dc, output int nd, output int mt,
                           output logic [5:0] cv, output logic [11:0] rs);
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_tlen = 6'(tl); bus.i_rlen = 6'(rl);
        dc = -1; nd = 0; mt = 0; cv = '0; rs = '0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (bus.o_done) begin
                nd++;
                if (dc < 0) dc = n;
            end
            if (bus.o_busy && int'(bus.o_tile) > mt) mt = int'(bus.o_tile);
            if (bus.o_ena && bus.o_tsrc != '0) cv = bus.o_colvalid;
            if (n == cap_at) rs = bus.o_rsrc;
            bus.i_start = (n == pulse_at);
            if (n == 1) begin
                bus.i_tlen = 6'($urandom); bus.i_rlen = 6'($urandom);
            end
            if (stall_at > 0) stall_in = (n >= stall_at && n < stall_at + 3);
            if (dc >= 0 && n >= dc + 4) break;
        end
        bus.i_start = 1'b0; stall_in = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, nd, mt, w;
        logic [5:0]  cv;
        logic [11:0] rs;
        bus.i_start = 1'b0; bus.i_tlen = '0; bus.i_rlen = '0;
        repeat (3) @(negedge clk);
        `CHK("rst_busy", bus.o_busy, 0);
        `CHK("rst_ena", bus.o_ena, 0);
        `CHK("rst_tsrc", bus.o_tsrc, 0);
        `CHK("rst_rsrc", bus.o_rsrc, 0);
        `CHK("rst_colvalid", bus.o_colvalid, 0);
        `CHK("rst_tile", bus.o_tile, 0);
        nrst = 1'b1; chk_on = 1'b1;

        run_job(6, 6, 0, 0, 1, dc, nd, mt, cv, rs);
        `CHK("j66_done_cyc", dc, 18);
        `CHK("j66_ndone", nd, 1);
        `CHK("j66_colvalid", cv, 6'b111111);
        `CHK("j66_rsrc_k0", rs, 12'b100000000000);

        run_job(4, 14, 0, 0, 36, dc, nd, mt, cv, rs);
        `CHK("j414_done_cyc", dc, 46);
        `CHK("j414_ndone", nd, 1);
        `CHK("j414_maxtile", mt, 2);
        `CHK("j414_colvalid", cv, 6'b110000);
        `CHK("j414_rsrc_t2k5", rs, 12'b000000000011);

        run_job(1, 1, 0, 0, 2, dc, nd, mt, cv, rs);
        `CHK("j11_done_cyc", dc, 13);
        `CHK("j11_colvalid", cv, 6'b100000);
        `CHK("j11_rsrc_k1", rs, 12'b001100000000);

        run_job(6, 6, 0, 10, 0, dc, nd, mt, cv, rs);
        `CHK("pulse_done_cyc", dc, 18);
        `CHK("pulse_ndone", nd, 1);
        `CHK("pulse_maxtile", mt, 0);

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.i_start = 1'b1;
            bus.i_tlen = (i == 0) ? 6'd0 : 6'd6;
            bus.i_rlen = (i == 0) ? 6'd6 : 6'd33;
            @(negedge clk);
            `CHK("err_pulse", bus.o_err, 1);
            `CHK("err_busy", bus.o_busy, 0);
            `CHK("err_ena", bus.o_ena, 0);
            bus.i_start = 1'b0;
            @(negedge clk);
            `CHK("err_clear", bus.o_err, 0);
            `CHK("err_busy2", bus.o_busy, 0);
        end

        @(negedge clk);
        bus.i_start = 1'b1; bus.i_tlen = 6'd6; bus.i_rlen = 6'd6;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
        end
        `CHK("pre_abort_tindex", bus.o_tindex, 5);
        nrst = 1'b0;
        #1;
        `CHK("abort_busy", bus.o_busy, 0);
        `CHK("abort_ena", bus.o_ena, 0);
        `CHK("abort_tindex", bus.o_tindex, 0);
        `CHK("abort_tsrc", bus.o_tsrc, 0);
        `CHK("abort_colvalid", bus.o_colvalid, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        run_job(6, 6, 0, 0, 1, dc, nd, mt, cv, rs);
        `CHK("rerun_done_cyc", dc, 18);
        `CHK("rerun_ndone", nd, 1);

`ifdef SYSTARR_CTRL_STALL_EN
        run_job(6, 6, 9, 0, 0, dc, nd, mt, cv, rs);
        `CHK("stall_done_cyc", dc, 21);
        `CHK("stall_ndone", nd, 1);
`endif

        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            bus.i_start = ($urandom_range(0, 11) == 0);
            bus.i_tlen  = pick_len();
            bus.i_rlen  = pick_len();
`ifdef SYSTARR_CTRL_STALL_EN
            stall_in = ($urandom_range(0, 7) == 0);
`endif
        end
        bus.i_start = 1'b0; stall_in = 1'b0;
        w = 0;
        while (bus.o_busy && w < 600) begin
            @(negedge clk);
            w++;
        end
        `CHK("drain_idle", bus.o_busy, 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
